shift_ram_dyn: RTL and testbench
================================

SHIFT_RAM_DYN -- requirements
Module: shift_ram_dyn

Interface
REQ-001 The block SHALL take parameter C_WIDTH, default 16, the bit width of one channel sample.
REQ-002 The block SHALL take parameter C_CHANNELS, default 1, the number of parallel channels sharing one pointer set.
REQ-003 The block SHALL take parameter C_DEPTH, default 16, the maximum delay in samples, legal range 2..1024.
REQ-004 The block SHALL take parameter C_ADDR_WIDTH, default 4, the width of A, which must be at least clog2(C_DEPTH).
REQ-005 The block SHALL take parameter C_REG_LAST_BIT, default 0, where 1 adds an output register stage.
REQ-006 The block SHALL take parameter C_HAS_CE, default 0, where 0 ties the internal CE to 1.
REQ-007 The block SHALL have port CLK, input, 1 bit: the single clock, with all state on its rising edge.
REQ-008 The block SHALL have port ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port CE, input, 1 bit: clock enable, used only when C_HAS_CE=1.
REQ-010 The block SHALL have port SCLR, input, 1 bit: synchronous flush.
REQ-011 The block SHALL have port D_VALID, input, 1 bit: a sample is present on D.
REQ-012 The block SHALL have port D, input, C_CHANNELS*C_WIDTH bits: the sample, with channel c in bits [c*C_WIDTH +: C_WIDTH].
REQ-013 The block SHALL have port A, input, C_ADDR_WIDTH bits: the run-time delay select, giving delay = A+1 samples.
REQ-014 The block SHALL have port Q, output, C_CHANNELS*C_WIDTH bits: the delayed sample.
REQ-015 The block SHALL have port Q_VALID, output, 1 bit: Q holds a genuine delayed sample.

Function
REQ-016 The block SHALL define "advance" as CE=1 and D_VALID=1 and SCLR=0 at a rising CLK edge.
REQ-017 The block SHALL store samples in a circular buffer of C_DEPTH words, each C_CHANNELS*C_WIDTH bits wide, with a write pointer WPTR.
REQ-018 On each advance, the block SHALL write D to mem[WPTR] and set WPTR to (WPTR+1) mod C_DEPTH, wrapping from C_DEPTH-1 to 0.
REQ-019 On each advance, the block SHALL increment a fill counter FILL, which saturates at C_DEPTH.
REQ-020 On every edge with CE=1, the block SHALL load A_REG from A, regardless of D_VALID.
REQ-021 The block SHALL load A_REG with C_DEPTH-1 when A is at least C_DEPTH or contains X/Z bits.
REQ-022 With C_REG_LAST_BIT=0, Q SHALL equal mem[(WPTR-1-A_REG) mod C_DEPTH], combinationally from registered state.
REQ-023 With C_REG_LAST_BIT=0, Q_VALID SHALL equal (FILL > A_REG).
REQ-024 With C_REG_LAST_BIT=0, after the advance that writes sample s_k, Q SHALL equal s_(k-A), giving one edge of latency for A=0.
REQ-025 The block SHALL force Q to all zeros whenever Q_VALID=0.
REQ-026 With C_REG_LAST_BIT=1, Q and Q_VALID SHALL be the REQ-022/REQ-023 values registered on every edge with CE=1, adding exactly one cycle of latency.
REQ-027 When CE=0, the block SHALL hold all state (memory, WPTR, FILL, A_REG and output register) unchanged, and SCLR SHALL be ignored.
REQ-028 When D_VALID=0, the block SHALL hold memory, WPTR and FILL, and Q SHALL be unchanged unless A_REG changes.
REQ-029 When A increases at run time, Q_VALID SHALL drop if FILL is not greater than the new A_REG, and SHALL reassert only after enough advances.
REQ-030 When A decreases, Q SHALL move to the newer sample on the next edge with no loss of Q_VALID.
REQ-031 SCLR=1 with CE=1 SHALL set WPTR=0, FILL=0 and Q_VALID=0, with the output register cleared in the same edge.
REQ-032 SCLR SHALL take priority over a simultaneous advance, so that the sample on D is dropped.
REQ-033 The block SHALL NOT clear memory contents on SCLR or reset, because stale data is masked by FILL.
REQ-034 All channels SHALL share WPTR, FILL and A_REG, with no cross-channel bit mixing.

Reset
REQ-035 While ARESETN=0, asynchronously, the block SHALL set WPTR=0, FILL=0, A_REG=C_DEPTH-1, Q=0 and Q_VALID=0.
REQ-036 Deasserting ARESETN mid-stream SHALL discard all in-flight samples, and the first advance after release SHALL be treated as s_0.
REQ-037 Reset deassertion SHALL take effect on the first rising CLK edge after ARESETN rises.

Verification
(All scenarios use C_WIDTH=8, C_CHANNELS=2, C_DEPTH=16, C_REG_LAST_BIT=0 unless stated.)
REQ-038 Fixed delay: with A=3, drive D={8'hk,8'h80+k} for k=0..19 every cycle -> Q_VALID rises after the 4th write, Q={8'h00,8'h80}, and then tracks s_(k-3).
REQ-039 Gaps and CE: with A=2 and D_VALID toggling 1,0,1,0, plus CE=0 for 3 cycles -> Q changes only on advance edges, and FILL, WPTR and Q are frozen while CE=0.
REQ-040 Wrap and maximum: with A=15, drive 40 writes -> WPTR wraps 15 to 0 twice, and Q equals s_(k-15) from write 16 onward.
REQ-041 Run-time length: after steady state at A=2, step A to 10 -> Q_VALID holds because FILL=16, and Q jumps to s_(k-10); after SCLR, step A 0 to 5 -> Q_VALID low until 6 writes.
REQ-042 Flush and reset: assert SCLR concurrently with D_VALID -> Q_VALID=0 and the sample is dropped; pulse ARESETN low between edges -> Q=0 and Q_VALID=0 immediately.
REQ-043 Registered output and clamp: with C_REG_LAST_BIT=1, A=0 -> Q lags D by 2 edges; A=5'h1F with C_ADDR_WIDTH=5 -> behaves as A=15.

Source files
------------

// File: rtl/shift_ram_dyn.sv
// shift_ram_dyn: run-time selectable delay line (delay = A+1) over a circular buffer.
// All channels share one write pointer, fill count and delay register.
module shift_ram_dyn #(
  parameter int C_WIDTH        = 16,
  parameter int C_CHANNELS     = 1,
  parameter int C_DEPTH        = 16,
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_REG_LAST_BIT = 0,
  parameter int C_HAS_CE       = 0
) (
  input  logic                             CLK,
  input  logic                             ARESETN,
  input  logic                             CE,
  input  logic                             SCLR,
  input  logic                             D_VALID,
  input  logic [C_CHANNELS*C_WIDTH-1:0]    D,
  input  logic [C_ADDR_WIDTH-1:0]          A,
  output logic [C_CHANNELS*C_WIDTH-1:0]    Q,
  output logic                             Q_VALID
);
  localparam int W  = C_CHANNELS * C_WIDTH;
  localparam int PW = $clog2(C_DEPTH);
  localparam int FW = $clog2(C_DEPTH + 1);
  logic          ce, sclr, adv, qv_c;
  logic [PW-1:0] wptr_q, wptr_d, a_reg_q, a_reg_d, rd_idx;
  logic [PW:0]   rd_sum;
  logic [FW-1:0] fill_q, fill_d;
  logic [W-1:0]  q_c;
  logic [W-1:0]  mem [C_DEPTH];
  always_comb begin
    ce      = (C_HAS_CE != 0) ? CE : 1'b1;
    sclr    = ce & SCLR;
    adv     = ce & D_VALID & ~SCLR;
    wptr_d  = sclr ? '0 : !adv ? wptr_q : (wptr_q == PW'(C_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    fill_d  = sclr ? '0 : (adv && fill_q != FW'(C_DEPTH)) ? fill_q + 1'b1 : fill_q;
    a_reg_d = !ce ? a_reg_q : ($isunknown(A) || 32'(A) >= C_DEPTH) ? PW'(C_DEPTH - 1) : PW'(A);
    // wptr-1-a_reg kept non-negative by adding C_DEPTH, then reduced once
    rd_sum  = {1'b0, wptr_q} + (PW+1)'(C_DEPTH - 1) - {1'b0, a_reg_q};
    rd_idx  = PW'(rd_sum >= (PW+1)'(C_DEPTH) ? rd_sum - (PW+1)'(C_DEPTH) : rd_sum);
    qv_c    = fill_q > FW'(a_reg_q);
    q_c     = qv_c ? mem[rd_idx] : '0;
  end
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q  <= '0;
      fill_q  <= '0;
      a_reg_q <= PW'(C_DEPTH - 1);
    end else begin
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      a_reg_q <= a_reg_d;
    end
  end
  // stale words are masked by fill, so the array needs no reset
  always_ff @(posedge CLK) begin
    if (adv) mem[wptr_q] <= D;
  end
  if (C_REG_LAST_BIT != 0) begin : g_reg
    logic [W-1:0] q_q, q_d;
    logic         qv_q, qv_d;
    always_comb begin
      qv_d = !ce ? qv_q : (!sclr && qv_c);
      q_d  = !ce ? q_q : sclr ? '0 : q_c;
    end
    always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
        q_q  <= '0;
        qv_q <= 1'b0;
      end else begin
        q_q  <= q_d;
        qv_q <= qv_d;
      end
    end
    assign Q       = q_q;
    assign Q_VALID = qv_q;
  end else begin : g_comb
    assign Q       = q_c;
    assign Q_VALID = qv_c;
  end
endmodule

// File: tb/tb_shift_ram_dyn.sv
// tb_shift_ram_dyn: vector table, directed corner sequences and random traffic
// against a sample-history queue model for unregistered and registered outputs.
module tb_shift_ram_dyn;
  logic        CLK, ARESETN, CE, SCLR, D_VALID;
  logic [15:0] D, Q0, Q1;
  logic [4:0]  A;
  logic        QV0, QV1;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] hist[$];
  int          a_m;
  logic [16:0] r1;

  shift_ram_dyn #(.C_WIDTH(8), .C_CHANNELS(2), .C_DEPTH(16), .C_ADDR_WIDTH(5),
                  .C_REG_LAST_BIT(0), .C_HAS_CE(1)) dut0 (
    .CLK(CLK), .ARESETN(ARESETN), .CE(CE), .SCLR(SCLR), .D_VALID(D_VALID),
    .D(D), .A(A), .Q(Q0), .Q_VALID(QV0));
  shift_ram_dyn #(.C_WIDTH(8), .C_CHANNELS(2), .C_DEPTH(16), .C_ADDR_WIDTH(5),
                  .C_REG_LAST_BIT(1), .C_HAS_CE(1)) dut1 (
    .CLK(CLK), .ARESETN(ARESETN), .CE(CE), .SCLR(SCLR), .D_VALID(D_VALID),
    .D(D), .A(A), .Q(Q1), .Q_VALID(QV1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic ce, sclr, dv;
    logic [15:0] d;
    logic [4:0] a;
    logic eqv;
    logic [15:0] eq;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected unregistered output: the sample written a_m advances ago, if it exists.
  function automatic logic [16:0] comb_exp();
    int n;
    n = hist.size();
    if (n > a_m) return {1'b1, hist[n-1-a_m]};
    return 17'h0;
  endfunction

  task automatic model_reset();
    hist.delete();
    a_m = 15;
    r1  = '0;
  endtask

  task automatic model_edge(input logic ce, input logic sclr, input logic dv,
                            input logic [15:0] d, input logic [4:0] a);
    logic [16:0] e;
    e = comb_exp();
    if (ce) begin
      r1 = sclr ? 17'h0 : e;
      if (sclr) hist.delete();
      else if (dv) begin
        hist.push_back(d);
        if (hist.size() > 16) void'(hist.pop_front());
      end
      a_m = ($isunknown(a) || a >= 16) ? 15 : int'(a);
    end
  endtask

  task automatic step(input logic ce, input logic sclr, input logic dv,
                      input logic [15:0] d, input logic [4:0] a);
    logic [16:0] e;
    CE = ce; SCLR = sclr; D_VALID = dv; D = d; A = a;
    @(posedge CLK);
    model_edge(ce, sclr, dv, d, a);
    #1;
    e = comb_exp();
    chk("q0", 32'(Q0), 32'(e[15:0]));
    chk("qv0", 32'(QV0), 32'(e[16]));
    chk("q1", 32'(Q1), 32'(r1[15:0]));
    chk("qv1", 32'(QV1), 32'(r1[16]));
  endtask

  initial begin
    ARESETN = 1'b0; CE = 1'b1; SCLR = 1'b0; D_VALID = 1'b0; D = '0; A = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q0", 32'(Q0), 0);
    chk("rst_qv0", 32'(QV0), 0);
    chk("rst_q1", 32'(Q1), 0);
    chk("rst_qv1", 32'(QV1), 0);
    #3 ARESETN = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 16'h0102, 5'd0,  1'b1, 16'h0102};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0304, 5'd0,  1'b1, 16'h0304};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'hffff, 5'd1,  1'b1, 16'h0102};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h5555, 5'd0,  1'b1, 16'h0102};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h7777, 5'd0,  1'b0, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h1111, 5'd1,  1'b0, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h2222, 5'd1,  1'b1, 16'h1111};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h3333, 5'd31, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ce, tbl[i].sclr, tbl[i].dv, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d_q", i), 32'(Q0), 32'(tbl[i].eq));
      chk($sformatf("tbl%0d_qv", i), 32'(QV0), 32'(tbl[i].eqv));
    end

    // Fixed delay A=3: valid after the 4th write with s_0
    step(1, 1, 0, 0, 3);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 1, {8'(k), 8'(8'h80 + k)}, 3);
      if (k == 2) chk("fix_qv_early", 32'(QV0), 0);
      if (k == 3) begin
        chk("fix_qv", 32'(QV0), 1);
        chk("fix_q", 32'(Q0), 32'h0080);
      end
    end

    // Gaps and CE freeze
    for (int k = 0; k < 4; k++) step(1, 0, k % 2 == 0, 16'h4000 + 16'(k), 2);
    for (int k = 0; k < 3; k++) step(0, k == 1, 1, 16'hdead, 7);

    // Wrap at maximum delay; A='x clamps to the maximum
    step(1, 1, 0, 0, 15);
    for (int k = 0; k < 40; k++) step(1, 0, 1, 16'(k * 16'h0103), (k == 20) ? 5'bx : 5'd15);

    // Run-time length change with full buffer, then growth after flush
    for (int k = 0; k < 20; k++) step(1, 0, 1, 16'h6000 + 16'(k), 2);
    step(1, 0, 1, 16'h6100, 10);
    chk("grow_qv_hold", 32'(QV0), 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 16'h7000, 0);
    for (int k = 1; k < 6; k++) begin
      step(1, 0, 1, 16'h7000 + 16'(k), 5);
      chk("grow_qv_low", 32'(QV0), 32'(k == 5));
    end
    step(1, 0, 1, 16'h7100, 1);

    // Flush wins over a simultaneous advance
    step(1, 1, 1, 16'hbeef, 0);
    chk("sclr_qv", 32'(QV0), 0);
    step(1, 0, 0, 0, 0);
    chk("sclr_drop", 32'(QV0), 0);

    // Random traffic with one asynchronous reset pulse between edges
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
           16'($urandom), ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : A);
      if (i == 200) begin
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_q0", 32'(Q0), 0);
        chk("arst_qv0", 32'(QV0), 0);
        chk("arst_q1", 32'(Q1), 0);
        chk("arst_qv1", 32'(QV1), 0);
        model_reset();
        #1 ARESETN = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
